seg_serial_rx: RTL and testbench
================================

# seg_serial_rx

Serial-to-parallel receiver for the four-wire shift-register stream (`CLK`, `DO`, `PEN`, `CLR`) that drives the LED and seven-segment boards. It samples the stream in the system clock domain and reconstructs the parallel word. It also flags malformed frames. Uses: loopback self-check of the LED/segment driver path, and accepting display data from a second board through a PMOD header.

## Interface
Parameters:
- `WIDTH`, 16: bits per frame; legal range 2..64. Use 64 for the segment board.
- `INVERT`, 0: when 1, `pdata` is the bitwise complement of the received bits. This matches the LED path, which transmits `~data`.

Ports:
- `clk`  in  1: system clock; must run at least 6x the serial clock rate.
- `reset`  in  1: synchronous, active-high reset.
- `s_clk`  in  1: serial shift clock, asynchronous; bit taken on its rising edge.
- `s_do`  in  1: serial data, asynchronous.
- `s_pen`  in  1: parallel-enable/latch, asynchronous; frame ends on its rising edge.
- `s_clr`  in  1: asynchronous, active-low clear of the in-flight frame.
- `pdata`  out  WIDTH: last good frame.
- `valid`  out  1: one-cycle pulse when `pdata` updates.
- `frame_err`  out  1: one-cycle pulse when a frame is rejected.
- `busy`  out  1: high while a partial frame is held (state SHIFT or OVER).
- `err_cnt`  out  8: saturating count of rejected frames. Present only with `SEG_RX_ERRCNT_EN`.

## Operation
- Each serial input passes through a 2-FF synchronizer, then a third register for edge detection. Rising edges of `s_clk` and `s_pen`, and the low level of `s_clr`, are evaluated on the synchronized signals only.
- Shift register `sr[WIDTH-1:0]`. On each `s_clk` rise: `sr <= {sr[WIDTH-2:0], s_do_sync}`. The first bit received ends up as the MSB of `pdata`.
- The bit counter `cnt` is `$clog2(WIDTH+2)` bits wide and drives the state machine:
  - IDLE: `cnt=0`. An `s_clk` rise moves to SHIFT with `cnt=1`.
  - SHIFT: `1<=cnt<=WIDTH`. An `s_clk` rise increments `cnt`; if `cnt` was already WIDTH, it moves to OVER.
  - OVER: more than WIDTH bits seen. Further `s_clk` rises still shift `sr`, but `cnt` stays fixed.
- `s_pen` rise, any state:
  - If in SHIFT with `cnt==WIDTH`: `pdata <= INVERT ? ~sr : sr`, pulse `valid`.
  - Otherwise (IDLE, short frame, or OVER): pulse `frame_err`; `pdata` holds.
  - In both cases, return to IDLE and set `cnt=0`.
- `s_clr` synchronized low: clear `sr` and `cnt`, go to IDLE. `pdata` holds; no pulse is issued.
- Priority within one cycle:
  - `reset` overrides everything.
  - Then `s_clr` low; any `s_clk` or `s_pen` edge in that cycle is ignored.
  - Then `s_clk` and `s_pen` together: the bit is shifted first, and the `s_pen` decision uses the post-shift `sr` and `cnt`. A final bit arriving with PEN therefore completes a valid frame.
- `busy` = (state != IDLE), registered.
- Reset values:
  - `pdata`: `INVERT ? {WIDTH{1'b1}} : 0`.
  - `valid`, `frame_err`, `busy`, `err_cnt`: 0.
  - `sr`, `cnt`: 0; state IDLE.
  - Synchronizer stages: `s_clk`/`s_pen` stages reset to 0, `s_clr` stages reset to 1. A line already high at reset release therefore produces an edge (see Timing).

## Timing
- Edge-to-effect latency is 3 `clk` edges. If a pin is stable before edge k, the resulting `sr`/`pdata`/pulse change is visible after edge k+2.
- `s_clk`, `s_pen`: each high and low phase must be at least 3 `clk` cycles. `s_do` must be stable from 2 cycles before to 2 cycles after the `s_clk` rise. Shorter pulses are unsupported and may be missed.
- `valid` and `frame_err` are high for exactly one cycle and are mutually exclusive.
- Reset mid-frame discards the partial frame with no pulse. Because the sync stages reset to 0, a line held high across reset release is seen as a rise 3 edges later. Benches must hold `s_clk`/`s_pen` low during reset.
- Back-to-back frames need no gap beyond the minimum phase times.

## Configuration
- `SEG_RX_ERRCNT_EN` defined:
  - `err_cnt` port exists.
  - It increments on every `frame_err` pulse and saturates at 255.
  - It clears only on `reset`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, INVERT=0: send 0xA5C3 MSB-first, then PEN → `pdata=16'hA5C3`, `valid` one cycle exactly 3 edges after the PEN rise, `busy` back to 0.
- WIDTH=16, INVERT=1: send 0x00FF → `pdata=16'hFF00`, `valid` pulses.
- 15 bits then PEN → `frame_err` one cycle, `pdata` unchanged; 17 bits then PEN → `frame_err`; with `SEG_RX_ERRCNT_EN`, `err_cnt=2`.
- 8 bits, `s_clr` low for 4 cycles, then a full 0x1234 frame → `pdata=16'h1234`, no `frame_err`.
- 16th `s_clk` rise and PEN rise in the same synchronized cycle → `valid`, and `pdata` includes the 16th bit.
- `reset` asserted after 10 bits, then a full 0xBEEF frame → `pdata=16'hBEEF`, no `frame_err`; 300 short frames → `err_cnt=255`.

Source files
------------

// File: rtl/seg_serial_rx.sv
// Serial-to-parallel receiver for the CLK/DO/PEN/CLR shift-register stream, sampled in the clk domain.
// Optional feature: define SEG_RX_ERRCNT_EN to add the saturating err_cnt rejected-frame counter.
module seg_serial_rx #(
    parameter int WIDTH  = 16,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_clk,
    input  logic             s_do,
    input  logic             s_pen,
    input  logic             s_clr,
    output logic [WIDTH-1:0] pdata,
    output logic             valid,
    output logic             frame_err,
`ifdef SEG_RX_ERRCNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(WIDTH + 1);
    localparam logic [WIDTH-1:0] PDATA_RST = INVERT ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_OVER
    } state_t;

    // clk/pen carry a third stage for rise detection; do/clr are used as levels
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [2:0] pen_sync_q, pen_sync_d;
    logic [1:0] do_sync_q, do_sync_d;
    logic [1:0] clr_sync_q, clr_sync_d;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    logic clk_rise, pen_rise, clr_low;

    assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    assign pen_rise = pen_sync_q[1] & ~pen_sync_q[2];
    assign clr_low  = ~clr_sync_q[1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], s_clk};
        pen_sync_d  = {pen_sync_q[1:0], s_pen};
        do_sync_d   = {do_sync_q[0], s_do};
        clr_sync_d  = {clr_sync_q[0], s_clr};
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        pdata_d     = pdata_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (clr_low) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else begin
            if (clk_rise) begin
                sr_d = {sr_q[WIDTH-2:0], do_sync_q[1]};
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_SHIFT;
                        cnt_d   = CNT_W'(1);
                    end
                    ST_SHIFT: begin
                        if (cnt_q == CNT_FULL) begin
                            state_d = ST_OVER;
                            cnt_d   = CNT_OVER;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            // PEN judges the post-shift view so a last bit arriving with PEN still counts
            if (pen_rise) begin
                if (state_d == ST_SHIFT && cnt_d == CNT_FULL) begin
                    pdata_d = INVERT ? ~sr_d : sr_d;
                    valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '0;
            pen_sync_q  <= '0;
            do_sync_q   <= '0;
            clr_sync_q  <= '1;
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            pdata_q     <= PDATA_RST;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            pen_sync_q  <= pen_sync_d;
            do_sync_q   <= do_sync_d;
            clr_sync_q  <= clr_sync_d;
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            pdata_q     <= pdata_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SEG_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

    assign pdata     = pdata_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seg_serial_rx.sv
// Scoreboard bench: two receivers (INVERT=0/1) share one serial stream; monitors check each pulse.
module tb_seg_serial_rx;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_clk = 1'b0, s_do = 1'b0, s_pen = 1'b0, s_clr = 1'b1;
    logic [W-1:0] pdata0, pdata1;
    logic valid0, valid1, ferr0, ferr1, busy0, busy1;
`ifdef SEG_RX_ERRCNT_EN
    logic [7:0] err_cnt0, err_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic         is_err;
        logic [W-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [W-1:0] last_good = '0;

    always #5 clk = ~clk;

    seg_serial_rx #(.WIDTH(W), .INVERT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .s_clk(s_clk), .s_do(s_do), .s_pen(s_pen), .s_clr(s_clr),
        .pdata(pdata0), .valid(valid0), .frame_err(ferr0),
`ifdef SEG_RX_ERRCNT_EN
        .err_cnt(err_cnt0),
`endif
        .busy(busy0)
    );

    seg_serial_rx #(.WIDTH(W), .INVERT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .s_clk(s_clk), .s_do(s_do), .s_pen(s_pen), .s_clr(s_clr),
        .pdata(pdata1), .valid(valid1), .frame_err(ferr1),
`ifdef SEG_RX_ERRCNT_EN
        .err_cnt(err_cnt1),
`endif
        .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // expected response for a frame; data is the pattern as received (non-inverted view)
    task automatic expect_frame(input logic is_err, input logic [W-1:0] data);
        exp_t e;
        if (!is_err) last_good = data;
        e.is_err = is_err;
        e.data   = is_err ? last_good : data;
        q0.push_back(e);
        e.data = ~e.data;
        q1.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        s_do = b;
        cyc(2);
        s_clk = 1'b1;
        cyc(4);
        s_clk = 1'b0;
        cyc(2);
    endtask

    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pen_pulse();
        s_pen = 1'b1;
        cyc(4);
        s_pen = 1'b0;
        cyc(4);
    endtask

    // monitors pop and compare whenever a DUT presents a pulse
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (valid0 || ferr0)) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL mon0_unexpected: valid=%0b err=%0b with empty queue", valid0, ferr0);
            end else begin
                e = q0.pop_front();
                check("mon0_kind", {valid0, ferr0}, {~e.is_err, e.is_err});
                check("mon0_pdata", pdata0, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (valid1 || ferr1)) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL mon1_unexpected: valid=%0b err=%0b with empty queue", valid1, ferr1);
            end else begin
                e = q1.pop_front();
                check("mon1_kind", {valid1, ferr1}, {~e.is_err, e.is_err});
                check("mon1_pdata", pdata1, e.data);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        s_clk = 1'b0;
        s_pen = 1'b0;
        s_clr = 1'b1;
        last_good = '0;
        cyc(4);
        reset = 1'b0;
        cyc(2);
    endtask

    initial begin
        do_reset();
        check("rst_pdata0", pdata0, 16'h0000);
        check("rst_pdata1", pdata1, 16'hFFFF);
        check("rst_busy", {busy0, busy1}, 2'b00);
        check("rst_pulses", {valid0, ferr0, valid1, ferr1}, 4'b0000);
`ifdef SEG_RX_ERRCNT_EN
        check("rst_errcnt", err_cnt0, 8'd0);
`endif

        // 0xA5C3 with explicit PEN-to-valid latency check
        expect_frame(1'b0, 16'hA5C3);
        send_bits(64'hA5C3, 16);
        check("busy_mid", busy0, 1'b1);
        s_pen = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("lat_not_early", valid0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("lat_edge3", valid0, 1'b1);
        @(negedge clk);
        check("valid_one_cycle", valid0, 1'b0);
        cyc(2);
        s_pen = 1'b0;
        cyc(4);
        check("busy_after", busy0, 1'b0);
        check("pdata_a5c3", pdata0, 16'hA5C3);

        // 0x00FF: inverted receiver shows 0xFF00
        expect_frame(1'b0, 16'h00FF);
        send_bits(64'h00FF, 16);
        pen_pulse();
        check("inv_pdata", pdata1, 16'hFF00);

        // short and long frames
        expect_frame(1'b1, 16'h0);
        send_bits(64'h1234, 15);
        pen_pulse();
        check("short_hold", pdata0, 16'h00FF);
        expect_frame(1'b1, 16'h0);
        send_bits(64'h1_5555, 17);
        pen_pulse();
`ifdef SEG_RX_ERRCNT_EN
        check("errcnt_2", err_cnt0, 8'd2);
`endif

        // clear mid-frame, then a full frame
        send_bits(64'hFF, 8);
        s_clr = 1'b0;
        cyc(4);
        s_clr = 1'b1;
        cyc(4);
        check("clr_busy", busy0, 1'b0);
        expect_frame(1'b0, 16'h1234);
        send_bits(64'h1234, 16);
        pen_pulse();
        check("clr_pdata", pdata0, 16'h1234);

        // 16th bit rise coincides with PEN rise
        expect_frame(1'b0, 16'h8001);
        send_bits(64'h4000, 15);
        s_do = 1'b1;
        cyc(2);
        s_clk = 1'b1;
        s_pen = 1'b1;
        cyc(4);
        s_clk = 1'b0;
        s_pen = 1'b0;
        cyc(4);
        check("sim_pdata", pdata0, 16'h8001);

        // reset mid-frame, then a full frame
        send_bits(64'h3FF, 10);
        do_reset();
        check("midrst_pdata", pdata0, 16'h0000);
        expect_frame(1'b0, 16'hBEEF);
        send_bits(64'hBEEF, 16);
        pen_pulse();
        check("beef_pdata", pdata0, 16'hBEEF);

        // 300 empty frames: each is a PEN alone from IDLE
        for (int i = 0; i < 300; i++) begin
            expect_frame(1'b1, 16'h0);
            pen_pulse();
        end
        check("err_hold", pdata0, 16'hBEEF);
`ifdef SEG_RX_ERRCNT_EN
        check("errcnt_sat", err_cnt0, 8'd255);
`endif

        cyc(10);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
